oh_cellchk: RTL and testbench

OH_CELLCHK -- requirements
Module: oh_cellchk

---
 rtl/oh_cellchk.sv | 232 +++++++++++++++++++++++
 tb/tb_oh_cellchk.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oh_cellchk.sv
// oh_cellchk -- directed-vector checker for a single N-input logic cell.
//
// A run starts with a start pulse. Vectors arrive over a valid/ready
// handshake. Each accepted vector is driven onto the cell inputs (dut_in),
// allowed SETTLE cycles to propagate, and then the cell output z is compared
// once against the FUNC reduction of the applied vector. Matches and
// mismatches are counted with saturating counters. The first mismatching
// vector is captured, and a sticky error flag is raised. The run ends after
// the vector tagged vec_last has been compared.
//
// Parameters:
//   N      : cell input count (1..8)
//   FUNC   : "nand" | "nor" | "and" | "or" | "xor" | "xnor"
//   SETTLE : cycles from applying a vector to sampling z (0..255)
//   CW     : width of pass_count / fail_count
//
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   start                 : begin a run (honoured in IDLE or DONE only)
//   vec_valid/vec_in/vec_last, vec_ready : stimulus handshake
//   dut_in                : registered drive to the cell under test
//   z                     : observed cell output
//   busy, done            : run status (done held until the next start)
//   pass_count, fail_count: saturating result counters
//   first_fail_vec, error : first mismatching vector, sticky mismatch flag
module oh_cellchk #(
  parameter int    N      = 2,
  parameter string FUNC   = "nand",
  parameter int    SETTLE = 4,
  parameter int    CW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          vec_valid,
  input  logic [N-1:0]  vec_in,
  input  logic          vec_last,
  output logic          vec_ready,
  output logic [N-1:0]  dut_in,
  input  logic          z,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pass_count,
  output logic [CW-1:0] fail_count,
  output logic [N-1:0]  first_fail_vec,
  output logic          error
);

  localparam logic [2:0] F_NAND = 3'd0;
  localparam logic [2:0] F_NOR  = 3'd1;
  localparam logic [2:0] F_AND  = 3'd2;
  localparam logic [2:0] F_OR   = 3'd3;
  localparam logic [2:0] F_XOR  = 3'd4;
  localparam logic [2:0] F_XNOR = 3'd5;
  localparam logic [2:0] F_BAD  = 3'd7;

  localparam logic [2:0] FUNC_SEL =
      (FUNC == "nand") ? F_NAND :
      (FUNC == "nor")  ? F_NOR  :
      (FUNC == "and")  ? F_AND  :
      (FUNC == "or")   ? F_OR   :
      (FUNC == "xor")  ? F_XOR  :
      (FUNC == "xnor") ? F_XNOR : F_BAD;

  // An unknown FUNC can never produce a trustworthy verdict, so error is
  // pinned high for the life of the instance.
  localparam logic FUNC_BAD = (FUNC_SEL == F_BAD);

  localparam logic          SETTLE_ZERO = (SETTLE == 0);
  localparam logic [7:0]    SETTLE_M1   = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};

  if (FUNC_BAD) begin : g_bad_func
    $fatal(1, "oh_cellchk: FUNC is not one of nand/nor/and/or/xor/xnor");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCEPT  = 3'd1,
    S_SETTLE  = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Expected cell output for an applied vector.
  function automatic logic cell_ref_f(input logic [N-1:0] v);
    logic r;
    case (FUNC_SEL)
      F_NAND:  r = ~(&v);
      F_NOR:   r = ~(|v);
      F_AND:   r = &v;
      F_OR:    r = |v;
      F_XOR:   r = ^v;
      F_XNOR:  r = ~(^v);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [7:0]    settle_cnt_q, settle_cnt_d;
  logic          last_q, last_d;
  logic [N-1:0]  dut_in_q, dut_in_d;
  logic [CW-1:0] pass_count_q, pass_count_d;
  logic [CW-1:0] fail_count_q, fail_count_d;
  logic [N-1:0]  first_fail_vec_q, first_fail_vec_d;
  logic          error_q, error_d;
  logic          vec_ready_q, vec_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          expected_s;

  assign expected_s = cell_ref_f(dut_in_q);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d          = state_q;
    settle_cnt_d     = settle_cnt_q;
    last_d           = last_q;
    dut_in_d         = dut_in_q;
    pass_count_d     = pass_count_q;
    fail_count_d     = fail_count_q;
    first_fail_vec_d = first_fail_vec_q;
    error_d          = error_q | FUNC_BAD;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d          = S_ACCEPT;
          pass_count_d     = {CW{1'b0}};
          fail_count_d     = {CW{1'b0}};
          first_fail_vec_d = {N{1'b0}};
          error_d          = FUNC_BAD;
        end else begin
          state_d = state_q;
        end
      end
      S_ACCEPT: begin
        if (vec_valid && vec_ready_q) begin
          dut_in_d = vec_in;
          last_d   = vec_last;
          if (SETTLE_ZERO) begin
            state_d = S_COMPARE;
          end else begin
            state_d      = S_SETTLE;
            settle_cnt_d = SETTLE_M1;
          end
        end else begin
          state_d = S_ACCEPT;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == 8'd0) begin
          state_d = S_COMPARE;
        end else begin
          settle_cnt_d = settle_cnt_q - 8'd1;
        end
      end
      S_COMPARE: begin
        // Case equality so an X/Z on z is scored as a mismatch.
        if (z === expected_s) begin
          if (pass_count_q != CNT_MAX) begin
            pass_count_d = pass_count_q + CW'(1);
          end else begin
            pass_count_d = pass_count_q;
          end
        end else begin
          if (fail_count_q != CNT_MAX) begin
            fail_count_d = fail_count_q + CW'(1);
          end else begin
            fail_count_d = fail_count_q;
          end
          error_d = 1'b1;
          if (!error_q) begin
            first_fail_vec_d = dut_in_q;
          end else begin
            first_fail_vec_d = first_fail_vec_q;
          end
        end
        state_d = last_q ? S_DONE : S_ACCEPT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered, so they are decoded from the next state.
    vec_ready_d = (state_d == S_ACCEPT);
    busy_d      = (state_d == S_ACCEPT) || (state_d == S_SETTLE) ||
                  (state_d == S_COMPARE);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      settle_cnt_q     <= 8'd0;
      last_q           <= 1'b0;
      dut_in_q         <= {N{1'b0}};
      pass_count_q     <= {CW{1'b0}};
      fail_count_q     <= {CW{1'b0}};
      first_fail_vec_q <= {N{1'b0}};
      error_q          <= FUNC_BAD;
      vec_ready_q      <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      settle_cnt_q     <= settle_cnt_d;
      last_q           <= last_d;
      dut_in_q         <= dut_in_d;
      pass_count_q     <= pass_count_d;
      fail_count_q     <= fail_count_d;
      first_fail_vec_q <= first_fail_vec_d;
      error_q          <= error_d;
      vec_ready_q      <= vec_ready_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign vec_ready      = vec_ready_q;
  assign dut_in         = dut_in_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass_count     = pass_count_q;
  assign fail_count     = fail_count_q;
  assign first_fail_vec = first_fail_vec_q;
  assign error          = error_q;

endmodule

// File: tb/tb_oh_cellchk.sv
// tb_oh_cellchk -- self-checking bench for oh_cellchk.
// Three instances: a 2-input NAND checker (SETTLE=4), a 3-input XOR checker
// with SETTLE=0, and a CW=2 OR checker used for counter saturation.
module tb_oh_cellchk;

  localparam int S_MAIN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Main instance: N=2, nand, SETTLE=4, CW=16
  logic        start, vec_valid, vec_last, vec_ready, busy, done, error, z;
  logic [1:0]  vec_in, dut_in, first_fail_vec;
  logic [15:0] pass_count, fail_count;
  logic        stuck1;
  logic [3:0]  flip_mask;

  // Cell under test: a 2-input NAND, optionally stuck at 1 or inverted on
  // selected input codes.
  assign z = stuck1 ? 1'b1 : (~(dut_in[0] & dut_in[1]) ^ flip_mask[dut_in]);

  oh_cellchk #(.N(2), .FUNC("nand"), .SETTLE(S_MAIN), .CW(16)) u_main (
    .clk(clk), .reset(reset), .start(start), .vec_valid(vec_valid),
    .vec_in(vec_in), .vec_last(vec_last), .vec_ready(vec_ready),
    .dut_in(dut_in), .z(z), .busy(busy), .done(done),
    .pass_count(pass_count), .fail_count(fail_count),
    .first_fail_vec(first_fail_vec), .error(error)
  );

  // XOR instance: N=3, SETTLE=0
  logic        start2, valid2, last2, ready2, busy2, done2, err2, z2;
  logic [2:0]  vec2, din2, ffv2;
  logic [15:0] pass2, fail2;
  assign z2 = din2[0] ^ din2[1] ^ din2[2];

  oh_cellchk #(.N(3), .FUNC("xor"), .SETTLE(0), .CW(16)) u_xor (
    .clk(clk), .reset(reset), .start(start2), .vec_valid(valid2),
    .vec_in(vec2), .vec_last(last2), .vec_ready(ready2),
    .dut_in(din2), .z(z2), .busy(busy2), .done(done2),
    .pass_count(pass2), .fail_count(fail2),
    .first_fail_vec(ffv2), .error(err2)
  );

  // Saturation instance: N=2, or, SETTLE=1, CW=2
  logic       start3, valid3, last3, ready3, busy3, done3, err3, z3;
  logic [1:0] vec3, din3, ffv3, pass3, fail3;
  assign z3 = din3[0] | din3[1];

  oh_cellchk #(.N(2), .FUNC("or"), .SETTLE(1), .CW(2)) u_sat (
    .clk(clk), .reset(reset), .start(start3), .vec_valid(valid3),
    .vec_in(vec3), .vec_last(last3), .vec_ready(ready3),
    .dut_in(din3), .z(z3), .busy(busy3), .done(done3),
    .pass_count(pass3), .fail_count(fail3),
    .first_fail_vec(ffv3), .error(err3)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state for the main instance
  int         exp_pass, exp_fail;
  logic       exp_err;
  logic [1:0] exp_ffv;
  logic [1:0] cur_vec;
  logic       cur_last;
  logic [1:0] vq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Specification of the cell: NAND is 0 only when every input is 1.
  function automatic logic spec_nand(input logic [1:0] v);
    return (v == 2'b11) ? 1'b0 : 1'b1;
  endfunction

  // What the bench's cell model actually drives for a vector.
  function automatic logic cell_main(input logic [1:0] v);
    return stuck1 ? 1'b1 : (spec_nand(v) ^ flip_mask[v]);
  endfunction

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_pass = 0; exp_fail = 0; exp_err = 1'b0; exp_ffv = 2'b00;
    chk("start_ready", 32'(vec_ready), 32'd1);
    chk("start_busy",  32'(busy),      32'd1);
    chk("start_done",  32'(done),      32'd0);
    chk("start_pass",  32'(pass_count), 32'd0);
    chk("start_fail",  32'(fail_count), 32'd0);
    chk("start_err",   32'(error),      32'd0);
    chk("start_ffv",   32'(first_fail_vec), 32'd0);
  endtask

  task automatic send_one(input logic [1:0] v, input logic last, input int gap, input logic poke);
    for (int g = 0; g < gap; g++) begin
      vec_valid = 1'b0;
      start = poke;
      tick();
      start = 1'b0;
      chk("gap_ready", 32'(vec_ready), 32'd1);
      chk("gap_pass", 32'(pass_count), 32'(exp_pass));
    end
    vec_valid = 1'b1; vec_in = v; vec_last = last;
    tick();
    cur_vec = v; cur_last = last;
    vec_valid = 1'b0; vec_last = 1'b0;
    chk("xfer_ready", 32'(vec_ready), 32'd0);
    chk("xfer_dut_in", 32'(dut_in), 32'(v));
    chk("xfer_busy", 32'(busy), 32'd1);
  endtask

  task automatic finish_vec(input logic hold, input logic [1:0] nv, input logic nlast);
    logic ez, cz;
    if (hold) begin
      vec_valid = 1'b1; vec_in = nv; vec_last = nlast;
    end else begin
      vec_valid = 1'b0;
    end
    for (int k = 0; k < S_MAIN; k++) begin
      tick();
      chk("settle_ready", 32'(vec_ready), 32'd0);
      chk("settle_dut_in", 32'(dut_in), 32'(cur_vec));
      chk("settle_pass", 32'(pass_count), 32'(exp_pass));
    end
    ez = spec_nand(cur_vec);
    cz = cell_main(cur_vec);
    if (cz == ez) exp_pass++;
    else begin
      exp_fail++;
      if (!exp_err) exp_ffv = cur_vec;
      exp_err = 1'b1;
    end
    tick();
    chk("cmp_pass", 32'(pass_count), 32'(exp_pass));
    chk("cmp_fail", 32'(fail_count), 32'(exp_fail));
    chk("cmp_err",  32'(error), 32'(exp_err));
    chk("cmp_ffv",  32'(first_fail_vec), 32'(exp_ffv));
    chk("cmp_ready", 32'(vec_ready), cur_last ? 32'd0 : 32'd1);
    chk("cmp_done",  32'(done),      cur_last ? 32'd1 : 32'd0);
    chk("cmp_busy",  32'(busy),      cur_last ? 32'd0 : 32'd1);
  endtask

  task automatic run_list(input int max_gap, input logic hold, input logic poke);
    int n;
    logic [1:0] nv;
    n = vq.size();
    start_run();
    for (int i = 0; i < n; i++) begin
      nv = (i + 1 < n) ? vq[i+1] : 2'b00;
      send_one(vq[i], (i == n - 1), hold ? 0 : int'($urandom_range(0, max_gap)), poke);
      finish_vec(hold && (i < n - 1), nv, (i + 1 == n - 1));
    end
  endtask

  initial begin
    int exp_p;
    reset = 1'b1;
    start = 1'b0; vec_valid = 1'b0; vec_in = 2'b00; vec_last = 1'b0;
    stuck1 = 1'b0; flip_mask = 4'b0000;
    start2 = 1'b0; valid2 = 1'b0; vec2 = 3'b000; last2 = 1'b0;
    start3 = 1'b0; valid3 = 1'b0; vec3 = 2'b00; last3 = 1'b0;
    tick(); tick(); tick();
    chk("rst_ready", 32'(vec_ready), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_pass",  32'(pass_count), 32'd0);
    chk("rst_err",   32'(error), 32'd0);
    chk("rst_dut_in", 32'(dut_in), 32'd0);
    reset = 1'b0;
    vec_valid = 1'b1;
    tick(); tick();
    chk("idle_ready", 32'(vec_ready), 32'd0);
    chk("idle_busy",  32'(busy), 32'd0);
    chk("idle_dut_in", 32'(dut_in), 32'd0);
    vec_valid = 1'b0;

    // Exhaustive NAND against a healthy cell
    vq = '{2'b00, 2'b01, 2'b10, 2'b11};
    run_list(0, 1'b0, 1'b0);
    chk("nand_pass4", 32'(pass_count), 32'd4);
    chk("nand_fail0", 32'(fail_count), 32'd0);
    chk("nand_done", 32'(done), 32'd1);

    // Output stuck at 1: only vector 11 should fail
    stuck1 = 1'b1;
    run_list(0, 1'b0, 1'b0);
    chk("stuck_pass3", 32'(pass_count), 32'd3);
    chk("stuck_fail1", 32'(fail_count), 32'd1);
    chk("stuck_err",   32'(error), 32'd1);
    chk("stuck_ffv",   32'(first_fail_vec), 32'd3);
    stuck1 = 1'b0;

    // Backpressure: next vector held valid throughout SETTLE
    vq = '{2'b00, 2'b01, 2'b11};
    run_list(0, 1'b1, 1'b0);
    chk("bp_pass3", 32'(pass_count), 32'd3);

    // Randomised runs with random cell faults, gaps and stray start pulses
    for (int r = 0; r < 5; r++) begin
      flip_mask = 4'($urandom_range(0, 15));
      vq = {};
      for (int i = 0; i < int'($urandom_range(3, 8)); i++) vq.push_back(2'($urandom_range(0, 3)));
      run_list(3, 1'b0, 1'b1);
    end
    flip_mask = 4'b0000;

    // Reset in the middle of SETTLE after two passing vectors
    start_run();
    send_one(2'b00, 1'b0, 0, 1'b0); finish_vec(1'b0, 2'b00, 1'b0);
    send_one(2'b01, 1'b0, 0, 1'b0); finish_vec(1'b0, 2'b00, 1'b0);
    chk("mid_pass2", 32'(pass_count), 32'd2);
    send_one(2'b11, 1'b0, 0, 1'b0);
    tick(); tick();
    reset = 1'b1; vec_valid = 1'b1; vec_in = 2'b10;
    tick();
    chk("mid_rst_ready", 32'(vec_ready), 32'd0);
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_done",  32'(done), 32'd0);
    chk("mid_rst_pass",  32'(pass_count), 32'd0);
    chk("mid_rst_fail",  32'(fail_count), 32'd0);
    chk("mid_rst_err",   32'(error), 32'd0);
    chk("mid_rst_ffv",   32'(first_fail_vec), 32'd0);
    chk("mid_rst_dut_in", 32'(dut_in), 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_rst_ready", 32'(vec_ready), 32'd0);
      chk("post_rst_dut_in", 32'(dut_in), 32'd0);
      chk("post_rst_pass", 32'(pass_count), 32'd0);
    end
    vec_valid = 1'b0;
    vq = '{2'b11, 2'b10, 2'b01, 2'b00};
    run_list(1, 1'b0, 1'b0);
    chk("rerun_pass4", 32'(pass_count), 32'd4);

    // SETTLE=0 XOR: valid held high, one vector every two cycles
    start2 = 1'b1; tick(); start2 = 1'b0;
    chk("xor_start_ready", 32'(ready2), 32'd1);
    exp_p = 0;
    for (int v = 0; v < 8; v++) begin
      valid2 = 1'b1; vec2 = 3'(v); last2 = (v == 7);
      tick();
      chk("xor_xfer_ready", 32'(ready2), 32'd0);
      chk("xor_dut_in", 32'(din2), 32'(v));
      if ((($countones(3'(v)) % 2) == 1) == z2) exp_p++;
      tick();
      chk("xor_pass", 32'(pass2), 32'(exp_p));
      chk("xor_ready", 32'(ready2), (v == 7) ? 32'd0 : 32'd1);
    end
    valid2 = 1'b0; last2 = 1'b0;
    chk("xor_pass8", 32'(pass2), 32'd8);
    chk("xor_done", 32'(done2), 32'd1);
    chk("xor_busy", 32'(busy2), 32'd0);
    chk("xor_fail", 32'(fail2), 32'd0);
    chk("xor_err", 32'(err2), 32'd0);
    chk("xor_ffv", 32'(ffv2), 32'd0);

    // CW=2 saturation: five matching vectors must stop at 3
    start3 = 1'b1; tick(); start3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid3 = 1'b1; vec3 = 2'($urandom_range(0, 3)); last3 = (i == 4);
      tick();
      valid3 = 1'b0; last3 = 1'b0;
      chk("sat_xfer_ready", 32'(ready3), 32'd0);
      tick(); tick();
      chk("sat_pass", 32'(pass3), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
    end
    chk("sat_pass3", 32'(pass3), 32'd3);
    chk("sat_fail", 32'(fail3), 32'd0);
    chk("sat_err", 32'(err3), 32'd0);
    chk("sat_ffv", 32'(ffv3), 32'd0);
    chk("sat_done", 32'(done3), 32'd1);
    chk("sat_busy", 32'(busy3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
